// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: supervisory controller for the NGMUX SEL input of the ROC clock tree.
//   Watches the heartbeats from CLK0 and CLK1, declares each clock OK or lost, and fails
//   over between CLK0 (preferred) and CLK1. Switches are rate-limited by a settle window,
//   and firmware can force a selection. Everything runs on the free-running reference CLK.
// Ports:
//   CLK, RESET            reference clock, asynchronous active-high reset
//   HB0, HB1              heartbeats from the two muxed clock domains (async to CLK)
//   FORCE_EN, FORCE_SEL   firmware override of the selection
//   SEL                   NGMUX select (0 = CLK0, 1 = CLK1)
//   CLK0_OK, CLK1_OK      health flags
//   BUSY                  high during SWITCH and the following settle window
//   SWITCH_CNT            saturating count of SEL changes
// Build option: define CLK_SEL_AUTO_REVERT_EN to return to CLK0 as soon as it is healthy
//   again. Without it the selection is sticky and moves only when the current clock is
//   lost and the other one is OK.
// All outputs are registered.

// Heartbeat health monitor for one clock domain.
//   hb_i -> 2-FF synchronizer -> XOR edge register (3 CLK cycles to the edge pulse).
//   A watchdog counts reference cycles since the last edge; a good counter counts
//   consecutive timely edges. ok_o is registered from both counters.
module clk_sel_hmon #(
  parameter int TIMEOUT  = 64,
  parameter int GOOD_CNT = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic hb_i,
  output logic ok_o
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int GCW = $clog2(GOOD_CNT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);
  localparam logic [GCW-1:0] GC_MAX = GCW'(GOOD_CNT);

  logic           sync1_q, sync2_q, sync3_q;
  logic           edge_q,  edge_d;
  logic [WDW-1:0] wd_q,    wd_d;
  logic [GCW-1:0] good_q,  good_d;
  logic           ok_q,    ok_d;
  logic           timeout;

  // sync3_q only holds the previous synchronized level for the edge detector.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= hb_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign timeout = (wd_q == WD_MAX);

  always_comb begin
    edge_d = sync2_q ^ sync3_q;
    wd_d   = wd_q;
    good_d = good_q;
    ok_d   = ok_q;

    // Watchdog: clear on every edge, otherwise count up and park at TIMEOUT.
    if (edge_q) begin
      wd_d = '0;
    end else if (!timeout) begin
      wd_d = wd_q + WDW'(1);
    end

    // An edge that arrives while the watchdog sits at TIMEOUT is late; it restarts the
    // watchdog but does not count toward recovery.
    if (timeout) begin
      good_d = '0;
    end else if (edge_q && (good_q != GC_MAX)) begin
      good_d = good_q + GCW'(1);
    end

    if (timeout) begin
      ok_d = 1'b0;
    end else if (good_q == GC_MAX) begin
      ok_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      edge_q <= 1'b0;
      wd_q   <= '0;
      good_q <= '0;
      ok_q   <= 1'b0;
    end else begin
      edge_q <= edge_d;
      wd_q   <= wd_d;
      good_q <= good_d;
      ok_q   <= ok_d;
    end
  end

  assign ok_o = ok_q;

endmodule

module clk_sel_ctrl #(
  parameter int TIMEOUT  = 64,
  parameter int GOOD_CNT = 16,
  parameter int SETTLE   = 32,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             HB0,
  input  logic             HB1,
  input  logic             FORCE_EN,
  input  logic             FORCE_SEL,
  output logic             SEL,
  output logic             CLK0_OK,
  output logic             CLK1_OK,
  output logic             BUSY,
  output logic [CNT_W-1:0] SWITCH_CNT
);

  localparam int SCW = $clog2(SETTLE + 1);
  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SWITCH = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic             sel_q,    sel_d;
  logic             busy_q,   busy_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [SCW-1:0]   settle_q, settle_d;
  logic             ok0, ok1;
  logic             des;

  clk_sel_hmon #(
    .TIMEOUT  (TIMEOUT),
    .GOOD_CNT (GOOD_CNT)
  ) u_hmon0 (
    .CLK   (CLK),
    .RESET (RESET),
    .hb_i  (HB0),
    .ok_o  (ok0)
  );

  clk_sel_hmon #(
    .TIMEOUT  (TIMEOUT),
    .GOOD_CNT (GOOD_CNT)
  ) u_hmon1 (
    .CLK   (CLK),
    .RESET (RESET),
    .hb_i  (HB1),
    .ok_o  (ok1)
  );

  // Desired selection. With both clocks down nothing here asks for a change.
  always_comb begin
    des = sel_q;
    if (FORCE_EN) begin
      des = FORCE_SEL;
    end else if (!sel_q && !ok0 && ok1) begin
      des = 1'b1;
    end else if (sel_q && ok0) begin
`ifdef CLK_SEL_AUTO_REVERT_EN
      // Preferred clock is back: go home even if CLK1 is still fine.
      des = 1'b0;
`else
      if (!ok1) begin
        des = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;

    case (state_q)
      S_IDLE: begin
        // DES is only looked at here; a request that disappears during SWITCH or
        // SETTLE is simply never seen.
        if (des != sel_q) begin
          state_d = S_SWITCH;
        end
      end
      S_SWITCH: begin
        // IDLE saw DES != SEL and SEL is one bit, so the target is the inverse.
        sel_d    = ~sel_q;
        settle_d = SETTLE_LAST;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q - SCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
    end
  end

  assign SEL        = sel_q;
  assign BUSY       = busy_q;
  assign SWITCH_CNT = cnt_q;
  assign CLK0_OK    = ok0;
  assign CLK1_OK    = ok1;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Testbench for clk_sel_ctrl: directed sequence with a scoreboard of expected
// (SEL, SWITCH_CNT) pairs, pushed when a switch is provoked and popped when SEL moves.
module tb_clk_sel_ctrl;

  localparam int TIMEOUT  = 64;
  localparam int GOOD_CNT = 16;
  localparam int SETTLE   = 32;
  localparam int CNT_W    = 8;

  logic             CLK;
  logic             RESET;
  logic             HB0, HB1;
  logic             FORCE_EN, FORCE_SEL;
  logic             SEL, CLK0_OK, CLK1_OK, BUSY;
  logic [CNT_W-1:0] SWITCH_CNT;

  clk_sel_ctrl #(
    .TIMEOUT  (TIMEOUT),
    .GOOD_CNT (GOOD_CNT),
    .SETTLE   (SETTLE),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .HB0        (HB0),
    .HB1        (HB1),
    .FORCE_EN   (FORCE_EN),
    .FORCE_SEL  (FORCE_SEL),
    .SEL        (SEL),
    .CLK0_OK    (CLK0_OK),
    .CLK1_OK    (CLK1_OK),
    .BUSY       (BUSY),
    .SWITCH_CNT (SWITCH_CNT)
  );

  typedef struct {
    logic             sel;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int   n_vec = 0;
  int   n_err = 0;

  int   cyc = 0;
  logic hb0_en, hb1_en;
  int   hb0_n, hb1_n, hb0_last, hb0_c16, hb1_c16;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Heartbeat generator: when enabled, each HB toggles every 2 CLK cycles.
  // Records the cycle of the last toggle and of the 16th toggle since enable.
  initial begin
    HB0 = 1'b0;
    HB1 = 1'b0;
    hb0_n = 0; hb1_n = 0; hb0_last = 0; hb0_c16 = 0; hb1_c16 = 0;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (!hb0_en) hb0_n = 0;
      else if (cyc % 2 == 0) begin
        HB0 = ~HB0;
        hb0_n++;
        hb0_last = cyc;
        if (hb0_n == GOOD_CNT) hb0_c16 = cyc;
      end
      if (!hb1_en) hb1_n = 0;
      else if (cyc % 2 == 0) begin
        HB1 = ~HB1;
        hb1_n++;
        if (hb1_n == GOOD_CNT) hb1_c16 = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for SEL to move, then pop the scoreboard and compare.
  task automatic wait_switch(input string tag, output int at_cyc);
    logic sel0;
    int   t;
    exp_t e;
    sel0 = SEL;
    t = 0;
    while (SEL === sel0 && t < 100) begin
      tick();
      t++;
    end
    at_cyc = cyc;
    chk({tag, "_seen"}, 32'(SEL !== sel0), 1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_sel"}, 32'(SEL), 32'(e.sel));
      chk({tag, "_cnt"}, 32'(SWITCH_CNT), 32'(e.cnt));
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (BUSY !== 1'b0 && t < 100) begin
      tick();
      t++;
    end
    chk({tag, "_idle"}, 32'(BUSY), 0);
  endtask

  initial begin
    int   t, f, s, cnt0, nchg, last_chg, min_gap;
    logic prev_sel, sel_hold, exp_sel;
    logic [CNT_W-1:0] exp_cnt;

    RESET = 1'b1;
    FORCE_EN = 1'b0;
    FORCE_SEL = 1'b0;
    hb0_en = 1'b0;
    hb1_en = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_sel",  32'(SEL), 0);
    chk("rst_ok0",  32'(CLK0_OK), 0);
    chk("rst_ok1",  32'(CLK1_OK), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_cnt",  32'(SWITCH_CNT), 0);
    RESET = 1'b0;
    tick();

    // Both heartbeats running: OK rises 5 cycles after the 16th toggle
    // (2 sync + edge register + good counter + OK register).
    hb0_en = 1'b1;
    hb1_en = 1'b1;
    t = 0;
    while (!CLK0_OK && t < 200) begin tick(); t++; end
    chk("ok0_rise", 32'(CLK0_OK), 1);
    chk("ok0_rise_lat", 32'(cyc - hb0_c16), 5);
    t = 0;
    while (!CLK1_OK && t < 200) begin tick(); t++; end
    chk("ok1_rise", 32'(CLK1_OK), 1);
    chk("ok1_rise_lat", 32'(cyc - hb1_c16), 5);
    repeat (20) tick();
    chk("healthy_sel",  32'(SEL), 0);
    chk("healthy_busy", 32'(BUSY), 0);
    chk("healthy_cnt",  32'(SWITCH_CNT), 0);

    // Lose CLK0: OK falls TIMEOUT+5 cycles after the last toggle
    // (3 to the edge pulse, 1 to clear the watchdog, TIMEOUT to saturate, 1 for OK).
    hb0_en = 1'b0;
    sb_q.push_back('{1'b1, CNT_W'(1)});
    t = 0;
    while (CLK0_OK && t < 200) begin tick(); t++; end
    chk("ok0_fall", 32'(CLK0_OK), 0);
    chk("ok0_fall_lat", 32'(cyc - hb0_last), TIMEOUT + 5);
    chk("ok1_still", 32'(CLK1_OK), 1);
    f = cyc;
    wait_switch("failover", s);
    chk("failover_lat", 32'(s - f), 2);
    chk("failover_busy", 32'(BUSY), 1);
    wait_idle("failover");
    chk("busy_len", 32'(cyc - (f + 1)), SETTLE + 1);

    // Restart CLK0.
    hb0_en = 1'b1;
`ifdef CLK_SEL_AUTO_REVERT_EN
    sb_q.push_back('{1'b0, CNT_W'(2)});
`endif
    t = 0;
    while (!CLK0_OK && t < 200) begin tick(); t++; end
    chk("ok0_recover", 32'(CLK0_OK), 1);
`ifdef CLK_SEL_AUTO_REVERT_EN
    wait_switch("revert", s);
    wait_idle("revert");
`else
    repeat (60) tick();
    chk("sticky_sel", 32'(SEL), 1);
    chk("sticky_cnt", 32'(SWITCH_CNT), 1);
`endif

    // Forced selection toggling every 5 cycles: spacing and final value.
    FORCE_EN = 1'b1;
    FORCE_SEL = SEL;
    cnt0 = int'(SWITCH_CNT);
    prev_sel = SEL;
    nchg = 0;
    last_chg = -1;
    min_gap = 1000;
    for (int i = 0; i < 280; i++) begin
      tick();
      if (i < 200 && i % 5 == 4) FORCE_SEL = ~FORCE_SEL;
      if (SEL !== prev_sel) begin
        nchg++;
        if (last_chg >= 0 && cyc - last_chg < min_gap) min_gap = cyc - last_chg;
        last_chg = cyc;
        prev_sel = SEL;
      end
    end
    chk("force_final_sel", 32'(SEL), 32'(FORCE_SEL));
    chk("force_final_busy", 32'(BUSY), 0);
    chk("force_min_gap", 32'(min_gap >= SETTLE + 1), 1);
    chk("force_nchg", 32'(nchg >= 3), 1);
    chk("force_cnt", 32'(SWITCH_CNT), 32'(cnt0 + nchg));

    // Park on CLK0 under force so releasing force asks for nothing in either build.
    FORCE_SEL = 1'b0;
    t = 0;
    while (!(SEL === 1'b0 && BUSY === 1'b0) && t < 100) begin tick(); t++; end
    chk("park_sel", 32'(SEL), 0);
    FORCE_EN = 1'b0;

    // Both clocks lost: flags fall, SEL holds.
    sel_hold = SEL;
    hb0_en = 1'b0;
    hb1_en = 1'b0;
    t = 0;
    while ((CLK0_OK || CLK1_OK) && t < 300) begin tick(); t++; end
    chk("both_lost_ok0", 32'(CLK0_OK), 0);
    chk("both_lost_ok1", 32'(CLK1_OK), 0);
    repeat (40) tick();
    chk("both_lost_sel", 32'(SEL), 32'(sel_hold));
    chk("both_lost_busy", 32'(BUSY), 0);

    // Reset in the middle of a settle window.
    sb_q.push_back('{~sel_hold, SWITCH_CNT + CNT_W'(1)});
    FORCE_EN = 1'b1;
    FORCE_SEL = ~sel_hold;
    wait_switch("pre_reset", s);
    repeat (10) tick();
    chk("mid_settle_busy", 32'(BUSY), 1);
    #1;
    RESET = 1'b1;
    FORCE_EN = 1'b0;
    FORCE_SEL = 1'b0;
    #1;
    chk("rst2_sel",  32'(SEL), 0);
    chk("rst2_busy", 32'(BUSY), 0);
    chk("rst2_cnt",  32'(SWITCH_CNT), 0);
    repeat (2) tick();
    RESET = 1'b0;
    tick();

    // 300 forced switches: count saturates at 2^CNT_W-1.
    FORCE_EN = 1'b1;
    exp_sel = 1'b0;
    exp_cnt = '0;
    tick();
    for (int i = 0; i < 300; i++) begin
      exp_sel = ~exp_sel;
      FORCE_SEL = exp_sel;
      if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + CNT_W'(1);
      sb_q.push_back('{exp_sel, exp_cnt});
      wait_switch("sat", s);
    end
    wait_idle("sat");
    chk("sat_cnt", 32'(SWITCH_CNT), 255);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
